d_bank_ctrl: RTL and testbench

Sequencer/arbiter for a shared bank of WIDTH `d_pr_ps` flip-flops. Three requesters (clear, preset, load) compete for the bank. The block grants one operation at a time and drives the bank's d/en/pr/ps lines with guaranteed mutual exclusion and minimum pulse width. It returns a one-cycle acknowledge, so requesters never touch the bank's asynchronous controls directly.

---
 rtl/d_bank_pkg.sv | 32 +++
 rtl/d_bank_ctrl_pulse_timer.sv | 53 +++++
 rtl/d_bank_ctrl.sv | 131 +++++++++++++
 tb/tb_d_bank_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/d_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_bank_pkg
//  Description : Shared definitions for the d_bank_ctrl bank sequencer:
//                completion op codes, FSM state encoding and pulse-length
//                clamping helper.
//  Revision    : 1.0  initial release
// ============================================================================
package d_bank_pkg;

   // Operation codes reported on ack_op alongside ack
   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_CLR  = 2'd1;
   localparam logic [1:0] OP_PRE  = 2'd2;
   localparam logic [1:0] OP_LD   = 2'd3;

   // Sequencer state encoding
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_PRE  = 3'd2,
      ST_LOAD = 3'd3,
      ST_ACK  = 3'd4
   } state_e;

   // A pulse length of 0 is meaningless for the async controls; treat it as 1
   function automatic int pulse_eff(input int cyc);
      return (cyc < 1) ? 1 : cyc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/d_bank_ctrl_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_timer
//  Description : Loadable down-counter timing the pr/ps pulse. Reloads to the
//                pulse length on load, counts down while count_en is high and
//                saturates at 1, so it never wraps during an active state.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load            - reload counter (grant edge)
//                count_en        - decrement while pulse is active
//                done            - current cycle is the last pulse cycle
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_timer
   import d_bank_pkg::*;
#(
   parameter int PULSE_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic count_en,
   output logic done
);

   localparam int            P_EFF    = pulse_eff(PULSE_CYC);
   localparam int            CW       = $clog2(P_EFF + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(P_EFF);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (count_en && (cnt_q > ONE)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count value 1 marks the final pulse cycle; the FSM leaves on the next edge
   assign done = (cnt_q <= ONE);

endmodule
`default_nettype wire

// File: rtl/d_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : d_bank_ctrl
//  Description : Fixed-priority sequencer for a bank of d_pr_ps flops.
//                Grants one of clear/preset/load at a time, drives the bank
//                controls mutually exclusively, returns a one-cycle ack.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                clr_req, pre_req, ld_req   - level requests, held until ack
//                ld_data [WIDTH]            - load value, sampled on grant
//                busy, ack, ack_op[2]       - status / completion
//                bank_d, bank_en, bank_pr, bank_ps - bank drive (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module d_bank_ctrl
   import d_bank_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int PULSE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_req,
   input  logic             pre_req,
   input  logic             ld_req,
   input  logic [WIDTH-1:0] ld_data,
   output logic             busy,
   output logic             ack,
   output logic [1:0]       ack_op,
   output logic [WIDTH-1:0] bank_d,
   output logic             bank_en,
   output logic             bank_pr,
   output logic             bank_ps
);

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic [1:0]       ack_op_q, ack_op_d;
   logic [WIDTH-1:0] bank_d_q, bank_d_d;
   logic             bank_en_q, bank_en_d;
   logic             bank_pr_q, bank_pr_d;
   logic             bank_ps_q, bank_ps_d;
   logic             tmr_load, tmr_done;

   pulse_timer #(
      .PULSE_CYC (PULSE_CYC)
   ) u_pulse_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .count_en ((state_q == ST_CLR) || (state_q == ST_PRE)),
      .done     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      bank_d_d = bank_d_q;
      tmr_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d  = ST_CLR;
               tmr_load = 1'b1;
            end else if (pre_req) begin
               state_d  = ST_PRE;
               tmr_load = 1'b1;
            end else if (ld_req) begin
               state_d  = ST_LOAD;
               bank_d_d = ld_data;
            end
         end
         ST_CLR, ST_PRE: begin
            if (tmr_done) state_d = ST_ACK;
         end
         ST_LOAD: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they change on the same
      // edge as the state and come straight from flops.
      busy_d    = (state_d != ST_IDLE);
      bank_ps_d = (state_d == ST_CLR);
      bank_pr_d = (state_d == ST_PRE);
      bank_en_d = (state_d == ST_LOAD);
      ack_d     = (state_d == ST_ACK);
      ack_op_d  = OP_NONE;
      if (state_d == ST_ACK) begin
         case (state_q)
            ST_CLR:  ack_op_d = OP_CLR;
            ST_PRE:  ack_op_d = OP_PRE;
            ST_LOAD: ack_op_d = OP_LD;
            default: ack_op_d = OP_NONE;
         endcase
      end
   end

   // Async reset drops pr/ps/en at once and discards any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         ack_op_q  <= OP_NONE;
         bank_d_q  <= '0;
         bank_en_q <= 1'b0;
         bank_pr_q <= 1'b0;
         bank_ps_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         ack_op_q  <= ack_op_d;
         bank_d_q  <= bank_d_d;
         bank_en_q <= bank_en_d;
         bank_pr_q <= bank_pr_d;
         bank_ps_q <= bank_ps_d;
      end
   end

   assign busy    = busy_q;
   assign ack     = ack_q;
   assign ack_op  = ack_op_q;
   assign bank_d  = bank_d_q;
   assign bank_en = bank_en_q;
   assign bank_pr = bank_pr_q;
   assign bank_ps = bank_ps_q;

endmodule
`default_nettype wire

// File: tb/tb_d_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_bank_ctrl
//  Description : Self-checking bench for d_bank_ctrl driving a behavioural
//                bank of d_pr_ps cells; directed scenarios plus random
//                request mixes checked against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_d_bank_ctrl;

   localparam int W     = 4;
   localparam int PCYC  = 3;
   localparam int P_EFF = PCYC;

   logic         clk;
   logic         rst_n;
   logic         clr_req, pre_req, ld_req;
   logic [W-1:0] ld_data;
   logic         busy, ack;
   logic [1:0]   ack_op;
   logic [W-1:0] bank_d;
   logic         bank_en, bank_pr, bank_ps;

   logic [W-1:0] q;       // bank cell outputs
   logic [W-1:0] exp_q;   // model: expected bank contents
   logic [W-1:0] exp_d;   // model: last loaded value
   int           n_tests = 0;
   int           n_fail  = 0;

   d_bank_ctrl #(
      .WIDTH     (W),
      .PULSE_CYC (PCYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_req (clr_req),
      .pre_req (pre_req),
      .ld_req  (ld_req),
      .ld_data (ld_data),
      .busy    (busy),
      .ack     (ack),
      .ack_op  (ack_op),
      .bank_d  (bank_d),
      .bank_en (bank_en),
      .bank_pr (bank_pr),
      .bank_ps (bank_ps)
   );

   // Bank of d_pr_ps cells: ps clears, pr presets (both async), en loads d
   always @(posedge clk or posedge bank_pr or posedge bank_ps) begin
      if (bank_ps)      q <= '0;
      else if (bank_pr) q <= '1;
      else if (bank_en) q <= bank_d;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // At most one bank control may be high in any cycle
   always @(negedge clk) begin
      chk("mutex", 32'($countones({bank_en, bank_pr, bank_ps}) <= 1), 32'd1);
   end

   // Serve one operation. Entry: at a negedge in an IDLE cycle with the
   // requests already driven; exit: at the negedge of the IDLE cycle after ACK.
   task automatic run_op(input bit late_ld);
      logic [1:0]   op;
      int           len;
      logic [W-1:0] cap;
      cap = ld_data;
      op  = clr_req ? 2'd1 : pre_req ? 2'd2 : ld_req ? 2'd3 : 2'd0;
      len = (op == 2'd3) ? 1 : P_EFF;
      @(posedge clk);
      @(negedge clk);
      if (op == 2'd3) begin
         exp_d   = cap;
         ld_data = W'($urandom);   // must not disturb the captured value
      end
      if (late_ld) ld_req = 1'b1;  // arrives while busy
      for (int k = 0; k < len; k++) begin
         chk("busy_act", 32'(busy), 32'd1);
         chk("ack_act", 32'(ack), 32'd0);
         chk("ctrl_act", 32'({bank_en, bank_pr, bank_ps}),
             32'({op == 2'd3, op == 2'd2, op == 2'd1}));
         chk("bank_d_act", 32'(bank_d), 32'(exp_d));
         @(negedge clk);
      end
      chk("ack", 32'(ack), 32'd1);
      chk("ack_op", 32'(ack_op), 32'(op));
      chk("busy_ack", 32'(busy), 32'd1);
      chk("ctrl_ack", 32'({bank_en, bank_pr, bank_ps}), 32'd0);
      case (op)
         2'd1: begin clr_req = 1'b0; exp_q = '0;    end
         2'd2: begin pre_req = 1'b0; exp_q = '1;    end
         2'd3: begin ld_req  = 1'b0; exp_q = exp_d; end
         default: ;
      endcase
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("ack_idle", 32'({ack, ack_op}), 32'd0);
      chk("q", 32'(q), 32'(exp_q));
      chk("bank_d_idle", 32'(bank_d), 32'(exp_d));
   endtask

   initial begin
      // Reset with every request high: everything must stay quiet
      rst_n   = 1'b0;
      clr_req = 1'b1;
      pre_req = 1'b1;
      ld_req  = 1'b1;
      ld_data = 4'b1010;
      exp_q   = '0;
      exp_d   = '0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_outs", 32'({busy, ack, ack_op, bank_en, bank_pr, bank_ps}), 32'd0);
         chk("rst_bank_d", 32'(bank_d), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Simultaneous requests: CLR, PRE, then LD of 1010
      run_op(1'b0);
      run_op(1'b0);
      run_op(1'b0);
      chk("q_load1010", 32'(q), 32'(4'b1010));

      // Preset then clear, bank_d untouched
      pre_req = 1'b1;
      run_op(1'b0);
      clr_req = 1'b1;
      run_op(1'b0);

      // Load requested during a CLR: served only after ACK + idle cycle
      ld_data = 4'b0110;
      clr_req = 1'b1;
      run_op(1'b1);
      run_op(1'b0);
      chk("q_masked_ld", 32'(q), 32'(4'b0110));

      // Random request mixes against the model
      for (int i = 0; i < 25; i++) begin
         logic [2:0] r;
         r       = 3'($urandom_range(1, 7));
         ld_data = W'($urandom);
         {clr_req, pre_req, ld_req} = r;
         while (clr_req || pre_req || ld_req) run_op(1'b0);
      end

      // Reset in the 2nd cycle of a preset: pr drops without a clock edge
      pre_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("pr_before_rst", 32'(bank_pr), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("pr_async_drop", 32'(bank_pr), 32'd0);
      chk("busy_async_drop", 32'(busy), 32'd0);
      pre_req = 1'b0;
      exp_q   = '1;
      exp_d   = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_ack_after_rst", 32'({ack, busy}), 32'd0);
      end
      chk("q_after_rst", 32'(q), 32'(exp_q));
      chk("bank_d_after_rst", 32'(bank_d), 32'(exp_d));

      // Controller still works after the aborted op
      ld_data = 4'b0011;
      ld_req  = 1'b1;
      run_op(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
